// File: rtl/game_reg_pkg.sv
// Shared definitions for the game attribute register bank: address-map
// offsets, event bit positions and the byte-enable write-merge helpers.
package game_reg_pkg;

  typedef logic [31:0] reg32_t;

  // Bit positions of the game events inside STATUS / IRQ_MASK
  localparam int EVT_HIT0  = 0;
  localparam int EVT_HIT1  = 1;
  localparam int EVT_COIN  = 2;
  localparam int EVT_CURE  = 3;
  localparam int EVT_SPEED = 4;

  // Control words sit directly after the software and hardware windows
  function automatic int STATUS_OFF(int sw, int hw);
    return sw + hw;
  endfunction

  function automatic int MASK_OFF(int sw, int hw);
    return sw + hw + 1;
  endfunction

  function automatic int FCNT_OFF(int sw, int hw);
    return sw + hw + 2;
  endfunction

  // Expand the 4 byte enables into a 32-bit bit mask
  function automatic reg32_t be_mask(logic [3:0] be);
    reg32_t m;
    m = '0;
    for (int b = 0; b < 4; b++)
      if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  // Replace only the enabled bytes of old with new data
  function automatic reg32_t be_merge(reg32_t old, reg32_t wd, logic [3:0] be);
    return (old & ~be_mask(be)) | (wd & be_mask(be));
  endfunction

endpackage

// File: rtl/avl_game_reg_bank_frame_edge_sync.sv
// frame_edge_sync: brings VSYNC into the CLK domain through two flops,
// detects its rising edge and emits a one-cycle frame_tick three cycles
// after that edge.
module frame_edge_sync (
  input  logic CLK,
  input  logic RESET,
  input  logic frame_sync,
  output logic frame_tick
);

  logic [1:0] sync;
  logic [1:0] prime;
  logic       hist;
  logic [1:0] dly_pipe;
  logic       rise;

  // The synchroniser output is only trusted once two clocks have passed
  // since reset; until then the edge history is forced high so a VSYNC
  // that is already high at reset cannot look like a fresh edge.
  assign rise = prime[1] & sync[1] & ~hist;

  // Synchroniser, edge history and tick delay line
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync       <= '0;
      prime      <= '0;
      hist       <= 1'b1;
      dly_pipe   <= '0;
      frame_tick <= 1'b0;
    end else begin
      sync       <= {sync[0], frame_sync};
      prime      <= {prime[0], 1'b1};
      hist       <= prime[1] ? sync[1] : 1'b1;
      dly_pipe   <= {dly_pipe[0], rise};
      frame_tick <= dly_pipe[1];
    end
  end

endmodule

// File: rtl/avl_game_reg_bank.sv
// avl_game_reg_bank: Avalon-MM register bank for game attributes.
// Software registers, hardware snapshot, sticky STATUS with IRQ mask and
// a frame counter. Transfers between software and the display/motion
// logic happen at VSYNC boundaries.
// Optional macro REG_BANK_IMMEDIATE_EN: sw_regs follows the working
// registers directly instead of the frame-shadowed copy.
module avl_game_reg_bank
  import game_reg_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int SW_REGS = 16,
  parameter int HW_REGS = 8,
  parameter int EVT_W   = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   AVL_READ,
  input  logic                   AVL_WRITE,
  input  logic                   AVL_CS,
  input  logic [3:0]             AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]      AVL_ADDR,
  input  logic [31:0]            AVL_WRITEDATA,
  output logic [31:0]            AVL_READDATA,
  input  logic                   frame_sync,
  output logic [SW_REGS*32-1:0]  sw_regs,
  input  logic [HW_REGS*32-1:0]  hw_regs,
  input  logic [EVT_W-1:0]       hw_event,
  output logic                   frame_tick,
  output logic                   irq
);

  localparam int S_OFF = STATUS_OFF(SW_REGS, HW_REGS);
  localparam int M_OFF = MASK_OFF(SW_REGS, HW_REGS);
  localparam int F_OFF = FCNT_OFF(SW_REGS, HW_REGS);

  logic [SW_REGS-1:0][31:0] wreg;
  logic [HW_REGS-1:0][31:0] snap;
  logic [EVT_W-1:0]         status;
  logic [EVT_W-1:0]         mask;
  logic [EVT_W-1:0]         status_clr;
  reg32_t                   fcnt;
  reg32_t                   addr32;
  reg32_t                   rd_mux;
  logic                     wr_en;
  logic                     rd_en;
  logic                     tick;

  assign addr32     = 32'(AVL_ADDR);
  assign wr_en      = AVL_CS & AVL_WRITE;
  assign rd_en      = AVL_CS & AVL_READ;
  assign frame_tick = tick;

  frame_edge_sync u_sync (
    .CLK        (CLK),
    .RESET      (RESET),
    .frame_sync (frame_sync),
    .frame_tick (tick)
  );

  // Working software registers, written byte-wise from the bus
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wreg <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < SW_REGS; i++)
        if (addr32 == 32'(i))
          wreg[i] <= be_merge(wreg[i], AVL_WRITEDATA, AVL_BYTE_EN);
    end
  end

`ifdef REG_BANK_IMMEDIATE_EN
  assign sw_regs = wreg;
`else
  logic [SW_REGS-1:0][31:0] shadow;

  // Frame-coherent copy; a write landing in the tick cycle waits a frame
  always_ff @(posedge CLK) begin
    if (RESET)     shadow <= '0;
    else if (tick) shadow <= wreg;
  end

  assign sw_regs = shadow;
`endif

  // Hardware snapshot and frame counter advance only at the boundary
  always_ff @(posedge CLK) begin
    if (RESET) begin
      snap <= '0;
      fcnt <= '0;
    end else if (tick) begin
      snap <= hw_regs;
      fcnt <= fcnt + 32'd1;
    end
  end

  // Only enabled bytes of a STATUS write clear bits
  assign status_clr = (wr_en && addr32 == 32'(S_OFF))
                    ? EVT_W'(AVL_WRITEDATA & be_mask(AVL_BYTE_EN)) : '0;

  // Sticky event flags (set beats clear) and the IRQ mask register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      status <= '0;
      mask   <= '0;
    end else begin
      status <= (status & ~status_clr) | hw_event;
      if (wr_en && addr32 == 32'(M_OFF))
        mask <= EVT_W'(be_merge(32'(mask), AVL_WRITEDATA, AVL_BYTE_EN));
    end
  end

  // Registered interrupt from the current flags
  always_ff @(posedge CLK) begin
    if (RESET) irq <= 1'b0;
    else       irq <= |(status & mask);
  end

  // Read decode; unmapped offsets return zero
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < SW_REGS; i++)
      if (addr32 == 32'(i)) rd_mux = wreg[i];
    for (int j = 0; j < HW_REGS; j++)
      if (addr32 == 32'(SW_REGS + j)) rd_mux = snap[j];
    if (addr32 == 32'(S_OFF)) rd_mux = 32'(status);
    if (addr32 == 32'(M_OFF)) rd_mux = 32'(mask);
    if (addr32 == 32'(F_OFF)) rd_mux = fcnt;
  end

  // Read data register, held until the next read
  always_ff @(posedge CLK) begin
    if (RESET)      AVL_READDATA <= '0;
    else if (rd_en) AVL_READDATA <= rd_mux;
  end

endmodule

// File: tb/tb_avl_game_reg_bank.sv
// Directed bench for avl_game_reg_bank with default parameters
// (SW_REGS=16, HW_REGS=8: STATUS=24, IRQ_MASK=25, FRAME_CNT=26).
module tb_avl_game_reg_bank;

  localparam int ADDR_W  = 12;
  localparam int SW_REGS = 16;
  localparam int HW_REGS = 8;
  localparam int EVT_W   = 16;
  localparam int S_OFF   = SW_REGS + HW_REGS;
  localparam int M_OFF   = S_OFF + 1;
  localparam int F_OFF   = S_OFF + 2;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic                  AVL_READ, AVL_WRITE, AVL_CS;
  logic [3:0]            AVL_BYTE_EN;
  logic [ADDR_W-1:0]     AVL_ADDR;
  logic [31:0]           AVL_WRITEDATA;
  logic [31:0]           AVL_READDATA;
  logic                  frame_sync;
  logic [SW_REGS*32-1:0] sw_regs;
  logic [HW_REGS*32-1:0] hw_regs;
  logic [EVT_W-1:0]      hw_event;
  logic                  frame_tick;
  logic                  irq;

  int checks = 0;
  int errors = 0;

  always #10 CLK = ~CLK;

  avl_game_reg_bank #(
    .ADDR_W(ADDR_W), .SW_REGS(SW_REGS), .HW_REGS(HW_REGS), .EVT_W(EVT_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE),
    .AVL_CS(AVL_CS), .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
    .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
    .frame_sync(frame_sync), .sw_regs(sw_regs), .hw_regs(hw_regs),
    .hw_event(hw_event), .frame_tick(frame_tick), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input int a, input logic [31:0] d, input logic [3:0] be);
    @(posedge CLK); #1;
    AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = ADDR_W'(a);
    AVL_WRITEDATA = d; AVL_BYTE_EN = be;
    @(posedge CLK); #1;
    AVL_CS = 1'b0; AVL_WRITE = 1'b0;
  endtask

  task automatic bus_rd(input int a, output logic [31:0] d);
    @(posedge CLK); #1;
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = ADDR_W'(a);
    @(posedge CLK); #1;
    d = AVL_READDATA;
    AVL_CS = 1'b0; AVL_READ = 1'b0;
  endtask

  // Raise VSYNC, wait (bounded) for the tick, let the boundary edge pass,
  // then drop VSYNC and let the synchroniser settle low.
  task automatic frame(input string tag);
    logic got;
    got = 1'b0;
    frame_sync = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (frame_tick) begin got = 1'b1; break; end
    end
    chk(tag, 32'(got), 32'd1);
    @(posedge CLK); #1;
    frame_sync = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
  endtask

  logic [31:0] rd;
  logic        seen;

  initial begin
    RESET = 1'b1; AVL_READ = 0; AVL_WRITE = 0; AVL_CS = 0; AVL_BYTE_EN = 4'hF;
    AVL_ADDR = '0; AVL_WRITEDATA = '0; hw_regs = '0; hw_event = '0;
    frame_sync = 1'b1;

    // 1: reset with VSYNC high, no spurious tick
    repeat (4) @(posedge CLK);
    #1;
    chk("rst_rdata", AVL_READDATA, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_sw_regs", sw_regs[31:0], 32'h0);
    RESET = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (frame_tick) seen = 1'b1;
    end
    chk("no_spurious_tick", 32'(seen), 32'h0);
    bus_rd(F_OFF, rd); chk("fcnt_rst", rd, 32'h0);
    frame_sync = 1'b0;
    repeat (5) @(posedge CLK);

    // 2: byte-enabled write, shadowed until boundary
    bus_wr(3, 32'hA5A5A5A5, 4'b0101);
    bus_rd(3, rd); chk("wr_be_rd", rd, 32'h00A500A5);
`ifdef REG_BANK_IMMEDIATE_EN
    chk("sw3_pre", sw_regs[3*32 +: 32], 32'h00A500A5);
`else
    chk("sw3_pre", sw_regs[3*32 +: 32], 32'h0);
`endif
    frame("tick_t2");
    chk("sw3_post", sw_regs[3*32 +: 32], 32'h00A500A5);

    // read coincident with write returns old value
    @(posedge CLK); #1;
    AVL_CS = 1; AVL_READ = 1; AVL_WRITE = 1; AVL_ADDR = 3;
    AVL_WRITEDATA = 32'hDEADBEEF; AVL_BYTE_EN = 4'hF;
    @(posedge CLK); #1;
    AVL_CS = 0; AVL_READ = 0; AVL_WRITE = 0;
    chk("rw_old", AVL_READDATA, 32'h00A500A5);
    bus_rd(3, rd); chk("rw_new", rd, 32'hDEADBEEF);

    // 3: hardware snapshot frozen between boundaries, RO
    hw_regs[31:0] = 32'h12;
    frame("tick_t3a");
    hw_regs[31:0] = 32'h34;
    bus_rd(SW_REGS, rd); chk("snap_hold", rd, 32'h12);
    bus_wr(SW_REGS, 32'hFFFF_FFFF, 4'hF);
    bus_rd(SW_REGS, rd); chk("snap_ro", rd, 32'h12);
    frame("tick_t3b");
    bus_rd(SW_REGS, rd); chk("snap_next", rd, 32'h34);

    // unmapped offset
    bus_wr(F_OFF + 1, 32'h5555_5555, 4'hF);
    bus_rd(F_OFF + 1, rd); chk("unmapped", rd, 32'h0);

    // 4: STATUS / IRQ
    bus_wr(M_OFF, 32'h1, 4'hF);
    bus_rd(M_OFF, rd); chk("mask_rd", rd, 32'h1);
    @(posedge CLK); #1; hw_event = 16'h1;
    @(posedge CLK); #1; hw_event = 16'h0;
    chk("irq_lat0", 32'(irq), 32'h0);
    @(posedge CLK); #1;
    chk("irq_set", 32'(irq), 32'h1);
    @(posedge CLK); #1;
    hw_event = 16'h1; AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = ADDR_W'(S_OFF);
    AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'hF;
    @(posedge CLK); #1;
    hw_event = 16'h0; AVL_CS = 0; AVL_WRITE = 0;
    bus_rd(S_OFF, rd); chk("set_wins", rd, 32'h1);
    bus_wr(S_OFF, 32'h1, 4'b1110);
    bus_rd(S_OFF, rd); chk("clr_be_off", rd, 32'h1);
    bus_wr(S_OFF, 32'h1, 4'hF);
    bus_rd(S_OFF, rd); chk("clr", rd, 32'h0);
    chk("irq_clr", 32'(irq), 32'h0);

    // 5: write in the tick cycle misses that shadow copy
    bus_wr(5, 32'h1111_1111, 4'hF);
    frame("tick_t5a");
    chk("sw5_a", sw_regs[5*32 +: 32], 32'h1111_1111);
    frame_sync = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (frame_tick) begin
        AVL_CS = 1; AVL_WRITE = 1; AVL_ADDR = 5;
        AVL_WRITEDATA = 32'h2222_2222; AVL_BYTE_EN = 4'hF;
        @(posedge CLK); #1;
        AVL_CS = 0; AVL_WRITE = 0;
        seen = 1'b1;
        break;
      end
    end
    chk("tick_t5b", 32'(seen), 32'h1);
    frame_sync = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
`ifdef REG_BANK_IMMEDIATE_EN
    chk("sw5_b", sw_regs[5*32 +: 32], 32'h2222_2222);
`else
    chk("sw5_b", sw_regs[5*32 +: 32], 32'h1111_1111);
`endif
    frame("tick_t5c");
    chk("sw5_c", sw_regs[5*32 +: 32], 32'h2222_2222);

    // 6: frame counter value and wrap
    bus_rd(F_OFF, rd); chk("fcnt_count", rd, 32'd6);
    force dut.fcnt = 32'hFFFF_FFFF;
    #1;
    release dut.fcnt;
    bus_rd(F_OFF, rd); chk("fcnt_pre", rd, 32'hFFFF_FFFF);
    frame("tick_t6");
    bus_rd(F_OFF, rd); chk("fcnt_wrap", rd, 32'h0);

    // reset mid-read discards the read
    bus_rd(3, rd); chk("pre_rst_rd", rd, 32'hDEADBEEF);
    @(posedge CLK); #1;
    AVL_CS = 1; AVL_READ = 1; AVL_ADDR = 3; RESET = 1;
    @(posedge CLK); #1;
    AVL_CS = 0; AVL_READ = 0;
    chk("rst_mid_read", AVL_READDATA, 32'h0);
    RESET = 0;
    bus_rd(3, rd); chk("wreg_rst", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
